// File: rtl/tv80_sram_bridge.sv
// tv80_sram_bridge: tv80s bus slave that maps memory, I/O and intack cycles onto a 1-cycle-latency sync SRAM
// Ports:
//   clk, reset                        rising-edge clock, synchronous active-high reset
//   m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, dout   core bus inputs
//   di, wait_n                        read data and wait request back to the core
//   sram_en, sram_we, sram_addr, sram_wdata, sram_rdata SRAM port
//   rd_count, wr_count                completed read / write accesses, wrapping
module tv80_sram_bridge #(
   parameter int unsigned WAIT_STATES   = 1,
   parameter logic [7:0]  IO_PAGE       = 8'h10,
   parameter logic [7:0]  INTACK_VECTOR = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   output logic [7:0]  di,
   output logic        wait_n,
   output logic        sram_en,
   output logic        sram_we,
   output logic [15:0] sram_addr,
   output logic [7:0]  sram_wdata,
   input  logic [7:0]  sram_rdata,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, HOLD} state_t;
   typedef enum logic [1:0] {K_MEM, K_IO, K_ACK} kind_t;
   state_t state;
   kind_t  kind;
   logic   mem_req, io_req, intack, still, cap;
   logic [3:0] cnt;
   assign mem_req = !mreq_n && rfsh_n && (!rd_n || !wr_n);
   assign io_req  = !iorq_n && m1_n && (!rd_n || !wr_n);
   assign intack  = !iorq_n && !m1_n;
   // HOLD only watches the request type that opened the cycle
   assign still   = kind == K_ACK ? intack : kind == K_IO ? io_req : mem_req;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         kind       <= K_MEM;
         di         <= 8'hFF;
         wait_n     <= 1'b1;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
         cnt        <= '0;
         cap        <= 1'b0;
      end else begin
         // read data appears the cycle after the strobe; capture it at the end of that cycle
         cap     <= sram_en && !sram_we;
         sram_en <= 1'b0;
         if (cap) di <= sram_rdata;
         case (state)
            IDLE:
               if (intack) begin
                  di    <= INTACK_VECTOR;
                  kind  <= K_ACK;
                  state <= HOLD;
               end else if (io_req || mem_req) begin
                  sram_addr  <= io_req ? {IO_PAGE, A[7:0]} : A;
                  sram_we    <= !wr_n;
                  sram_wdata <= dout;
                  kind       <= io_req ? K_IO : K_MEM;
                  sram_en    <= 1'b1;
                  state      <= ACCESS;
               end
            ACCESS: begin
               if (sram_we) wr_count <= wr_count + 16'd1;
               else rd_count <= rd_count + 16'd1;
               if (WAIT_STATES > 0) begin
                  wait_n <= 1'b0;
                  cnt    <= 4'(WAIT_STATES - 1);
                  state  <= WAIT;
               end else state <= HOLD;
            end
            WAIT:
               if (cnt == 4'd0) begin
                  wait_n <= 1'b1;
                  state  <= HOLD;
               end else cnt <= cnt - 4'd1;
            HOLD:
               if (!still) state <= IDLE;
         endcase
      end
   end
endmodule
